// File: rtl/bm_memory_writer.sv
// -----------------------------------------------------------------------------
// bm_memory_writer
//
// Fills a 2^BITS-word downstream memory with a stream of incoming words.
// A start pulse in IDLE begins a sweep at address 0. Each word accepted on
// the input handshake is written one cycle later through wr_en/wr_addr/wr_data.
// The sweep ends in DONE after the last address is written, or it is
// cancelled by abort.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high. in_ready is decoded combinationally from the state and from
// abort. It does not depend on in_valid. No word is buffered: in_valid seen
// outside FILL is simply dropped.
//
// Ports
//   clock        in   single rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin a sweep (used only in IDLE)
//   abort        in   cancel the active sweep (used only in FILL)
//   in_valid     in   in_data carries a word
//   in_data      in   incoming word [WORD_SIZE]
//   in_ready     out  word accepted this cycle when in_valid is high
//   wr_en        out  registered write strobe to the memory
//   wr_addr      out  registered write address [BITS]
//   wr_data      out  registered write data [WORD_SIZE]
//   busy         out  high while in FILL
//   done         out  one-cycle pulse when a sweep completes
//   word_count   out  words written in the current or last sweep [BITS+1]
//   dbg_state_o  out  FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module bm_memory_writer #(
  parameter int BITS      = 2,
  parameter int WORD_SIZE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [BITS-1:0]      wr_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [BITS:0]        word_count,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BITS-1:0] PTR_LAST = '1;

  state_t                 state_q, state_d;
  logic [BITS-1:0]        ptr_q, ptr_d;
  logic [BITS:0]          cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [BITS-1:0]        wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                   accept;

  // in_ready is decoded from the current state. Abort withdraws it in the
  // same cycle, so no word is taken in the cycle that cancels the sweep.
  assign in_ready = (state_q == FILL) && !abort;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        // Start wins over a simultaneous abort because abort is only
        // looked at in FILL.
        if (start) begin
          state_d = FILL;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end

      FILL: begin
        if (abort) begin
          // word_count keeps the words already written.
          state_d = IDLE;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          ptr_d     = ptr_q + 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // This state lasts one cycle. Start is ignored here, so a start
        // that coincides with done does not begin a new sweep.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == FILL);
  assign done        = (state_q == DONE);
  assign word_count  = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/bm_memory_writer.md
BM_MEMORY_WRITER -- requirements
Module: bm_memory_writer

Interface
REQ-001 The block SHALL have parameter BITS, default 2, address width; the memory depth is 2^BITS words.
REQ-002 The block SHALL have parameter WORD_SIZE, default 4, data word width.
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to begin a fill sweep.
REQ-006 Port abort, input, 1 bit: cancel an active sweep.
REQ-007 Port in_valid, input, 1 bit: in_data holds a word to write.
REQ-008 Port in_data, input, WORD_SIZE bits: incoming word.
REQ-009 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-010 Port wr_en, output, 1 bit: write strobe to the downstream memory.
REQ-011 Port wr_addr, output, BITS bits: write address to the downstream memory.
REQ-012 Port wr_data, output, WORD_SIZE bits: write data to the downstream memory.
REQ-013 Port busy, output, 1 bit: high while in FILL.
REQ-014 Port done, output, 1 bit: one-cycle pulse on sweep completion.
REQ-015 Port word_count, output, BITS+1 bits: words written in the current or last sweep.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, FILL and DONE.
REQ-017 In IDLE, when start=1, the FSM SHALL go to FILL, clear the address pointer and word_count to 0, and leave wr_en low.
REQ-018 in_ready SHALL equal (state==FILL) && !abort, decoded combinationally from the state.
REQ-019 A word SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-020 On the edge that accepts a word, the block SHALL register wr_en=1, wr_addr=pointer and wr_data=in_data, giving a latency of exactly 1 cycle from acceptance to strobe.
REQ-021 In every cycle without acceptance, wr_en SHALL be 0; wr_addr and wr_data SHALL hold their last values.
REQ-022 On acceptance, the pointer SHALL increment modulo 2^BITS and word_count SHALL increment by 1.
REQ-023 Acceptance at pointer 2^BITS-1 SHALL move the FSM to DONE; the pointer SHALL wrap to 0.
REQ-024 In DONE, done SHALL be 1 for exactly that cycle, in_ready SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-025 A start in FILL or DONE SHALL be ignored.
REQ-026 A start in the same cycle as done SHALL be ignored.
REQ-027 abort=1 in FILL SHALL force in_ready=0 that cycle and return the FSM to IDLE without asserting done.
REQ-028 On abort, word_count SHALL keep the number of words written before the abort.
REQ-029 A write registered on the edge before an abort SHALL still appear on wr_en.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 When start and abort are both 1 in IDLE, start SHALL take effect and abort SHALL be ignored.
REQ-032 in_valid while not in FILL SHALL be ignored and SHALL NOT be buffered.
REQ-033 busy SHALL be 1 exactly when the state is FILL.

Reset
REQ-034 When reset=1, asynchronously and regardless of clock, the block SHALL force: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, word_count=0, pointer=0.
REQ-035 A reset mid-sweep SHALL discard the sweep; no wr_en SHALL be issued while reset is high or on the first edge after its release.

Verification
REQ-036 Full sweep: BITS=2; pulse start; in_valid=1 with data 0xA,0xB,0xC,0xD on consecutive cycles -> wr_en high for 4 cycles, addresses 0,1,2,3 with data A,B,C,D, each 1 cycle after acceptance; done pulses once; word_count=4; state back to IDLE.
REQ-037 Gaps: in FILL, in_valid toggles 1,0,1,0,1,1 -> wr_en only on the cycle after each valid; addresses 0..3 contiguous; done after the 4th word.
REQ-038 Abort: after 2 words accepted, abort=1 -> in_ready=0 that cycle; no done; word_count=2; start restarts at address 0.
REQ-039 Reset mid-sweep: reset asserted between clock edges after 3 words -> all outputs 0 immediately; no further wr_en; next sweep begins at address 0.
REQ-040 Ignored inputs: in_valid=1 in IDLE -> in_ready=0, no wr_en; start during FILL -> pointer unaffected; start and abort together in IDLE -> enters FILL.
REQ-041 Back-to-back sweeps: start asserted in the done cycle -> ignored; start asserted one cycle later -> new sweep with word_count cleared to 0.
